// File: rtl/traffic_light_pkg.sv
// Shared phase encoding for the traffic light controller and its monitor,
// plus small lamp-decoding helpers.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PhaseSync   = 2'd0,
    PhaseRed    = 2'd1,
    PhaseGreen  = 2'd2,
    PhaseYellow = 2'd3
  } phase_e;

  // True when exactly one lamp is lit.
  function automatic logic lamps_onehot(input logic red, input logic green, input logic yellow);
    return (red & ~green & ~yellow) | (~red & green & ~yellow) | (~red & ~green & yellow);
  endfunction

  // Phase shown by a lamp sample; only meaningful when lamps_onehot() holds.
  function automatic phase_e lamp_phase(input logic red, input logic green, input logic yellow);
    if (red) begin
      return PhaseRed;
    end else if (green) begin
      return PhaseGreen;
    end else if (yellow) begin
      return PhaseYellow;
    end
    return PhaseSync;
  endfunction

  // The only permitted sequence is RED -> GREEN -> YELLOW -> RED.
  function automatic logic legal_step(input phase_e from_ph, input phase_e to_ph);
    return ((from_ph == PhaseRed)    && (to_ph == PhaseGreen))  ||
           ((from_ph == PhaseGreen)  && (to_ph == PhaseYellow)) ||
           ((from_ph == PhaseYellow) && (to_ph == PhaseRed));
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating dwell counter. clear restarts the count; when enable is also
// high the restarted count already includes the current cycle (loads 1).
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: restart on clear, otherwise saturating increment.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {{(CNT_W-1){1'b0}}, enable};
    end else if (enable && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for a RED -> GREEN -> YELLOW traffic light controller.
// Tracks the lamp phase, its dwell time, and flags one-hot, ordering and
// dwell-time violations. Completed-cycle statistics are built only when
// TRAFFIC_LIGHT_MONITOR_STATS_EN is defined; otherwise full_cycles reads 0.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int unsigned RED_TIME    = 5,
  parameter int unsigned GREEN_TIME  = 5,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             green,
  input  logic             yellow,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic             err_onehot,
  output logic             err_order,
  output logic             err_timing,
  output logic             err_any,
  output logic [CNT_W-1:0] full_cycles
);

  localparam logic [CNT_W-1:0] RedTimeW    = CNT_W'(RED_TIME);
  localparam logic [CNT_W-1:0] GreenTimeW  = CNT_W'(GREEN_TIME);
  localparam logic [CNT_W-1:0] YellowTimeW = CNT_W'(YELLOW_TIME);

  phase_e           phase_q, phase_d;
  // timed: the current phase was entered by a legal step and is checked.
  // over:  overstay already flagged, so no more timing checks this phase.
  logic             timed_q, timed_d;
  logic             over_q, over_d;
  logic             onehot_q, onehot_d;
  logic             order_q, order_d;
  logic             timing_q, timing_d;
  logic             any_q, any_d;
  logic             valid;
  phase_e           sample_ph;
  logic [CNT_W-1:0] phase_time;
  logic             tmr_clear, tmr_enable;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .count  (dwell)
  );

  assign valid     = lamps_onehot(red, green, yellow);
  assign sample_ph = lamp_phase(red, green, yellow);

  // Required dwell of the phase currently being tracked.
  always_comb begin
    phase_time = '0;
    case (phase_q)
      PhaseRed:    phase_time = RedTimeW;
      PhaseGreen:  phase_time = GreenTimeW;
      PhaseYellow: phase_time = YellowTimeW;
      default:     phase_time = '0;
    endcase
  end

  // Phase tracking and violation detection for the current lamp sample.
  always_comb begin
    phase_d    = phase_q;
    timed_d    = timed_q;
    over_d     = over_q;
    onehot_d   = 1'b0;
    order_d    = 1'b0;
    timing_d   = 1'b0;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;

    if (!valid) begin
      // Ambiguous sample: report it and freeze tracking.
      onehot_d = 1'b1;
    end else if (phase_q == PhaseSync) begin
      phase_d    = sample_ph;
      timed_d    = 1'b0;
      over_d     = 1'b0;
      tmr_clear  = 1'b1;
      tmr_enable = 1'b1;
    end else if (sample_ph == phase_q) begin
      tmr_enable = 1'b1;
      if (timed_q && !over_q && (dwell == phase_time)) begin
        timing_d = 1'b1;
        over_d   = 1'b1;
      end
    end else begin
      phase_d    = sample_ph;
      over_d     = 1'b0;
      tmr_clear  = 1'b1;
      tmr_enable = 1'b1;
      if (legal_step(phase_q, sample_ph)) begin
        timed_d = 1'b1;
        if (timed_q && !over_q && (dwell < phase_time)) begin
          timing_d = 1'b1;
        end
      end else begin
        order_d = 1'b1;
        timed_d = 1'b0;
      end
    end

    any_d = any_q | onehot_d | order_d | timing_d;
  end

  // Tracking state and registered violation outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q  <= PhaseSync;
      timed_q  <= 1'b0;
      over_q   <= 1'b0;
      onehot_q <= 1'b0;
      order_q  <= 1'b0;
      timing_q <= 1'b0;
      any_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      timed_q  <= timed_d;
      over_q   <= over_d;
      onehot_q <= onehot_d;
      order_q  <= order_d;
      timing_q <= timing_d;
      any_q    <= any_d;
    end
  end

  assign phase      = phase_q;
  assign err_onehot = onehot_q;
  assign err_order  = order_q;
  assign err_timing = timing_q;
  assign err_any    = any_q;

`ifdef TRAFFIC_LIGHT_MONITOR_STATS_EN
  // cyc_ok: the cycle that began at the current RED is still clean and timed.
  logic             cyc_ok_q, cyc_ok_d;
  logic [CNT_W-1:0] full_q, full_d;
  logic             close_cycle;

  assign close_cycle = valid && (phase_q == PhaseYellow) && (sample_ph == PhaseRed);

  // Qualify the running cycle and count it when YELLOW hands over to RED.
  always_comb begin
    cyc_ok_d = cyc_ok_q;
    full_d   = full_q;
    if (onehot_d || order_d || timing_d) begin
      cyc_ok_d = 1'b0;
    end
    if (close_cycle) begin
      if (cyc_ok_q && timed_q && !timing_d && (full_q != {CNT_W{1'b1}})) begin
        full_d = full_q + CNT_W'(1);
      end
      // The new RED was entered legally, so the next cycle starts clean.
      cyc_ok_d = 1'b1;
    end
  end

  // Cycle statistics registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_ok_q <= 1'b0;
      full_q   <= '0;
    end else begin
      cyc_ok_q <= cyc_ok_d;
      full_q   <= full_d;
    end
  end

  assign full_cycles = full_q;
`else
  assign full_cycles = '0;
`endif

endmodule
